// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STABLE  = 3'd1,
    ST_RELEASE = 3'd2,
    ST_READY   = 3'd3,
    ST_ERROR   = 3'd4
  } seq_state_t;

  localparam int LOCK_CNT_W = 8;

  function automatic int stage_idx_w(input int n_stages);
    return (n_stages <= 1) ? 1 : $clog2(n_stages);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with asynchronous active-low reset
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - lock-qualified, handshake-ordered release of per-stage resets
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_STAGES      = 3,
  parameter int STABLE_CYCLES = 1024,
  parameter int STAGE_TIMEOUT = 65535,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  locked_async,
  input  logic                  sw_reset_req,
  input  logic [N_STAGES-1:0]   stage_done,
  output logic [N_STAGES-1:0]   stage_rst_n,
  output logic                  all_ready,
  output logic                  timeout_err,
  output logic [2:0]            err_stage,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]            seq_state
);

  localparam int                IDX_W        = stage_idx_w(N_STAGES);
  localparam logic [CNT_W-1:0]  STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(STAGE_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_STAGE   = IDX_W'(N_STAGES - 1);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] stage_idx;
  logic             settle;
  logic             locked_s;
  logic             abort_lock;
  logic             abort_sw;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (locked_async),
    .q     (locked_s)
  );

  // Once past STABLE, locked_s can only read low here on a falling edge.
  assign abort_lock = ((state == ST_RELEASE) || (state == ST_READY) || (state == ST_ERROR))
                      && !locked_s;
  assign abort_sw   = sw_reset_req && (state != ST_IDLE);
  assign seq_state  = state;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      stage_idx     <= '0;
      settle        <= 1'b0;
      stage_rst_n   <= '0;
      all_ready     <= 1'b0;
      timeout_err   <= 1'b0;
      err_stage     <= '0;
      lock_loss_cnt <= '0;
    end else if (abort_lock || abort_sw) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      stage_idx   <= '0;
      settle      <= 1'b0;
      stage_rst_n <= '0;
      all_ready   <= 1'b0;
      if (abort_lock && (lock_loss_cnt != '1)) begin
        lock_loss_cnt <= lock_loss_cnt + 1'b1;
      end
      if (sw_reset_req) begin
        timeout_err <= 1'b0;
        err_stage   <= '0;
      end
    end else begin
      if (sw_reset_req) begin
        timeout_err <= 1'b0;
        err_stage   <= '0;
      end
      case (state)
        ST_IDLE: begin
          stage_rst_n <= '0;
          all_ready   <= 1'b0;
          cnt         <= '0;
          stage_idx   <= '0;
          if (locked_s) begin
            state <= ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= ST_RELEASE;
            cnt         <= '0;
            stage_idx   <= '0;
            settle      <= 1'b1;
            stage_rst_n <= N_STAGES'(1);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          // settle masks stage_done during the cycle the stage comes out of reset.
          if (!settle && stage_done[stage_idx]) begin
            cnt <= '0;
            if (stage_idx == LAST_STAGE) begin
              state     <= ST_READY;
              all_ready <= 1'b1;
            end else begin
              stage_idx   <= stage_idx + 1'b1;
              stage_rst_n <= stage_rst_n | (N_STAGES'(1) << (stage_idx + 1'b1));
              settle      <= 1'b1;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state       <= ST_ERROR;
            stage_rst_n <= '0;
            all_ready   <= 1'b0;
            timeout_err <= 1'b1;
            err_stage   <= 3'(stage_idx);
          end else begin
            cnt    <= cnt + 1'b1;
            settle <= 1'b0;
          end
        end
        ST_READY: begin
          all_ready <= 1'b1;
        end
        ST_ERROR: begin
          stage_rst_n <= '0;
          all_ready   <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
